// File: rtl/systolic_pkg.sv
// Shared constants, widths and FSM state type for the 8x8 systolic array sequencer.
package systolic_pkg;

  localparam int ARRAY_SIZE = 8;
  localparam int FIRST_OUT  = ARRAY_SIZE + 1;
  localparam int N_RD       = 2 * ARRAY_SIZE - 1;
  localparam int N_WR       = 2 * ARRAY_SIZE;
  localparam int LAST       = FIRST_OUT + N_WR - 1;

  // Widths shared with the array datapath.
  localparam int CYCLE_W = 9;
  localparam int MIDX_W  = 6;

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_GAP,
    S_DONE
  } state_t;

endpackage

// File: rtl/systolic_addr_gen.sv
// Read/write SRAM address adders: base + tile offset + position within the tile.
module systolic_addr_gen
  import systolic_pkg::*;
#(
  parameter int ADDR_WIDTH = 10,
  parameter int TILE_W     = 6
) (
  input  logic [ADDR_WIDTH-1:0] w_base,
  input  logic [ADDR_WIDTH-1:0] d_base,
  input  logic [ADDR_WIDTH-1:0] o_base,
  input  logic [TILE_W-1:0]     tile,
  input  logic [CYCLE_W-1:0]    cnt,
  input  logic [MIDX_W-1:0]     midx,
  output logic [ADDR_WIDTH-1:0] raddr_w,
  output logic [ADDR_WIDTH-1:0] raddr_d,
  output logic [ADDR_WIDTH-1:0] waddr
);

  logic [ADDR_WIDTH-1:0] rd_off;
  logic [ADDR_WIDTH-1:0] wr_off;

  // All sums are truncated to ADDR_WIDTH, so addresses wrap silently.
  assign rd_off  = ADDR_WIDTH'(tile) * ADDR_WIDTH'(N_RD) + ADDR_WIDTH'(cnt);
  assign wr_off  = ADDR_WIDTH'(tile) * ADDR_WIDTH'(N_WR) + ADDR_WIDTH'(midx);

  assign raddr_w = w_base + rd_off;
  assign raddr_d = d_base + rd_off;
  assign waddr   = o_base + wr_off;

endmodule

// File: rtl/systolic_ctrl.sv
// Tile sequencer for the systolic array: FSM, cycle/tile counters and registered
// SRAM/array control outputs, all computed from next-cycle values.
module systolic_ctrl
  import systolic_pkg::*;
#(
  parameter int ADDR_WIDTH = 10,
  parameter int TILE_W     = 6
) (
  input  logic                  clk,
  input  logic                  srst,
  input  logic                  start,
  input  logic [TILE_W-1:0]     tile_num,
  input  logic [ADDR_WIDTH-1:0] w_base,
  input  logic [ADDR_WIDTH-1:0] d_base,
  input  logic [ADDR_WIDTH-1:0] o_base,
  output logic                  busy,
  output logic                  done,
  output logic                  alu_start,
  output logic [CYCLE_W-1:0]    cycle_num,
  output logic [MIDX_W-1:0]     matrix_index,
  output logic                  sram_ren,
  output logic [ADDR_WIDTH-1:0] sram_raddr_w,
  output logic [ADDR_WIDTH-1:0] sram_raddr_d,
  output logic                  sram_wen,
  output logic [ADDR_WIDTH-1:0] sram_waddr
);

  state_t                state;
  logic [TILE_W-1:0]     t;
  logic [TILE_W-1:0]     tile_cnt;
  logic [ADDR_WIDTH-1:0] w_cfg, d_cfg, o_cfg;

  logic                  accept, last_cycle, tile_last;
  logic                  run_next, busy_next, done_next;
  logic                  rd_win, wr_win;
  logic [TILE_W-1:0]     t_next;
  logic [CYCLE_W-1:0]    cnt_next;
  logic [MIDX_W-1:0]     midx_next;
  logic [ADDR_WIDTH-1:0] w_sel, d_sel, o_sel;
  logic [ADDR_WIDTH-1:0] gen_raddr_w, gen_raddr_d, gen_waddr;

  assign accept     = (state == S_IDLE) && start;
  assign last_cycle = (state == S_RUN) && (cycle_num == CYCLE_W'(LAST));
  assign tile_last  = (TILE_W'(t + 1'b1) == tile_cnt);

  assign run_next  = (accept && (tile_num != '0)) || (state == S_GAP) ||
                     ((state == S_RUN) && !last_cycle);
  assign done_next = (accept && (tile_num == '0)) || (last_cycle && tile_last);
  assign busy_next = accept || (state == S_RUN) || (state == S_GAP);

  // Outputs are registered, so addresses are formed from the next-cycle view of
  // configuration, tile and counter; on acceptance that is the live inputs.
  assign w_sel     = accept ? w_base : w_cfg;
  assign d_sel     = accept ? d_base : d_cfg;
  assign o_sel     = accept ? o_base : o_cfg;
  assign t_next    = accept ? '0 : (last_cycle ? TILE_W'(t + 1'b1) : t);
  assign cnt_next  = ((state == S_RUN) && !last_cycle) ? CYCLE_W'(cycle_num + 1'b1) : '0;
  assign midx_next = MIDX_W'(cnt_next - CYCLE_W'(FIRST_OUT));
  assign rd_win    = run_next && (cnt_next < CYCLE_W'(N_RD));
  assign wr_win    = run_next && (cnt_next >= CYCLE_W'(FIRST_OUT)) &&
                     (cnt_next <= CYCLE_W'(LAST));

  systolic_addr_gen #(
    .ADDR_WIDTH (ADDR_WIDTH),
    .TILE_W     (TILE_W)
  ) u_addr_gen (
    .w_base  (w_sel),
    .d_base  (d_sel),
    .o_base  (o_sel),
    .tile    (t_next),
    .cnt     (cnt_next),
    .midx    (midx_next),
    .raddr_w (gen_raddr_w),
    .raddr_d (gen_raddr_d),
    .waddr   (gen_waddr)
  );

  // NOTE: every register here is assigned with <= so all of them update from the
  // same pre-edge values; a blocking = would leak new state into later lines.
  always_ff @(posedge clk) begin
    if (srst) begin
      state        <= S_IDLE;
      t            <= '0;
      tile_cnt     <= '0;
      w_cfg        <= '0;
      d_cfg        <= '0;
      o_cfg        <= '0;
      busy         <= 1'b0;
      done         <= 1'b0;
      alu_start    <= 1'b0;
      cycle_num    <= '0;
      matrix_index <= '0;
      sram_ren     <= 1'b0;
      sram_raddr_w <= '0;
      sram_raddr_d <= '0;
      sram_wen     <= 1'b0;
      sram_waddr   <= '0;
    end else begin
      case (state)
        S_IDLE: if (start) begin
          w_cfg    <= w_base;
          d_cfg    <= d_base;
          o_cfg    <= o_base;
          tile_cnt <= tile_num;
          state    <= (tile_num == '0) ? S_DONE : S_RUN;
        end
        S_RUN:   if (last_cycle) state <= tile_last ? S_DONE : S_GAP;
        S_GAP:   state <= S_RUN;
        S_DONE:  state <= S_IDLE;
        default: state <= S_IDLE;
      endcase

      t            <= t_next;
      busy         <= busy_next;
      done         <= done_next;
      alu_start    <= run_next;
      cycle_num    <= run_next ? cnt_next : '0;
      sram_ren     <= rd_win;
      sram_raddr_w <= rd_win ? gen_raddr_w : '0;
      sram_raddr_d <= rd_win ? gen_raddr_d : '0;
      sram_wen     <= wr_win;
      matrix_index <= wr_win ? midx_next : '0;
      sram_waddr   <= wr_win ? gen_waddr : '0;
    end
  end

endmodule

// File: tb/tb_systolic_ctrl.sv
// Directed self-checking bench for systolic_ctrl; one task per scenario.
module tb_systolic_ctrl;

  logic       clk = 1'b0;
  logic       srst;
  logic       start;
  logic [5:0] tile_num;
  logic [9:0] w_base, d_base, o_base;
  logic       busy, done, alu_start, sram_ren, sram_wen;
  logic [8:0] cycle_num;
  logic [5:0] matrix_index;
  logic [9:0] sram_raddr_w, sram_raddr_d, sram_waddr;

  int n_tests = 0;
  int n_fail  = 0;

  systolic_ctrl #(.ADDR_WIDTH(10), .TILE_W(6)) dut (
    .clk          (clk),
    .srst         (srst),
    .start        (start),
    .tile_num     (tile_num),
    .w_base       (w_base),
    .d_base       (d_base),
    .o_base       (o_base),
    .busy         (busy),
    .done         (done),
    .alu_start    (alu_start),
    .cycle_num    (cycle_num),
    .matrix_index (matrix_index),
    .sram_ren     (sram_ren),
    .sram_raddr_w (sram_raddr_w),
    .sram_raddr_d (sram_raddr_d),
    .sram_wen     (sram_wen),
    .sram_waddr   (sram_waddr)
  );

  always #5 clk = ~clk;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic launch(input logic [5:0] tn, input logic [9:0] wb, db, ob);
    tile_num = tn; w_base = wb; d_base = db; o_base = ob;
    start = 1'b1;
    tick;
    start = 1'b0;
  endtask

  task automatic test_reset;
    srst = 1'b1; start = 1'b0; tile_num = '0; w_base = '0; d_base = '0; o_base = '0;
    tick; tick;
    srst = 1'b0;
    n_tests++;
    if ({busy, done, alu_start, sram_ren, sram_wen} !== 5'b0) begin
      n_fail++; $display("FAIL reset_flags: got %b want 00000", {busy, done, alu_start, sram_ren, sram_wen});
    end
    n_tests++;
    if ({cycle_num, matrix_index} !== 15'b0) begin
      n_fail++; $display("FAIL reset_counters: got cyc=%0d mi=%0d want 0/0", cycle_num, matrix_index);
    end
    n_tests++;
    if ({sram_raddr_w, sram_raddr_d, sram_waddr} !== 30'b0) begin
      n_fail++; $display("FAIL reset_addr: got %h %h %h want 0", sram_raddr_w, sram_raddr_d, sram_waddr);
    end
    tick;
    n_tests++;
    if (busy !== 1'b0) begin
      n_fail++; $display("FAIL idle_busy: got %b want 0", busy);
    end
  endtask

  task automatic test_single_tile;
    int k, cn, done_k, wen_cnt;
    logic [9:0] first_wa, last_wa, exp_rw, exp_rd, exp_wa;
    logic [5:0] exp_mi;
    logic exp_ren, exp_wen;
    launch(6'd1, 10'h010, 10'h040, 10'h100);
    // Config changes after acceptance must have no effect.
    tile_num = 6'd7; w_base = 10'h2AA; d_base = 10'h155; o_base = 10'h3C3;
    k = 1; done_k = 0; wen_cnt = 0; first_wa = '1; last_wa = '0;
    while (done_k == 0 && k <= 40) begin
      if (done === 1'b1) begin
        done_k = k;
        n_tests++;
        if ({busy, alu_start, sram_ren, sram_wen} !== 4'b1000) begin
          n_fail++; $display("FAIL single_done_cycle: got %b want 1000", {busy, alu_start, sram_ren, sram_wen});
        end
      end else begin
        cn = k - 1;
        exp_ren = (cn < 15);
        exp_rw  = exp_ren ? 10'(16 + cn) : 10'h0;
        exp_rd  = exp_ren ? 10'(64 + cn) : 10'h0;
        exp_wen = (cn >= 9) && (cn <= 24);
        exp_mi  = exp_wen ? 6'(cn - 9) : 6'h0;
        exp_wa  = exp_wen ? 10'(256 + cn - 9) : 10'h0;
        n_tests++;
        if ({busy, alu_start, cycle_num} !== {1'b1, 1'b1, 9'(cn)}) begin
          n_fail++; $display("FAIL single_run k=%0d: got busy=%b alu=%b cyc=%0d want 1 1 %0d", k, busy, alu_start, cycle_num, cn);
        end
        n_tests++;
        if ({sram_ren, sram_raddr_w, sram_raddr_d} !== {exp_ren, exp_rw, exp_rd}) begin
          n_fail++; $display("FAIL single_read k=%0d: got %b %h %h want %b %h %h", k, sram_ren, sram_raddr_w, sram_raddr_d, exp_ren, exp_rw, exp_rd);
        end
        n_tests++;
        if ({sram_wen, matrix_index, sram_waddr} !== {exp_wen, exp_mi, exp_wa}) begin
          n_fail++; $display("FAIL single_write k=%0d: got %b %0d %h want %b %0d %h", k, sram_wen, matrix_index, sram_waddr, exp_wen, exp_mi, exp_wa);
        end
        if (sram_wen === 1'b1) begin
          wen_cnt++;
          if (wen_cnt == 1) first_wa = sram_waddr;
          last_wa = sram_waddr;
        end
        tick; k++;
      end
    end
    n_tests++;
    if (done_k != 26) begin
      n_fail++; $display("FAIL single_done_time: got %0d want 26", done_k);
    end
    n_tests++;
    if ({wen_cnt[7:0], first_wa, last_wa} !== {8'd16, 10'h100, 10'h10F}) begin
      n_fail++; $display("FAIL single_wen_span: got n=%0d %h..%h want 16 100..10f", wen_cnt, first_wa, last_wa);
    end
    tick;
    n_tests++;
    if ({busy, done} !== 2'b00) begin
      n_fail++; $display("FAIL single_after_done: got %b want 00", {busy, done});
    end
  endtask

  task automatic test_multi_tile;
    int k, gaps, done_k;
    launch(6'd3, 10'h020, 10'h080, 10'h200);
    k = 1; gaps = 0; done_k = 0;
    while (done_k == 0 && k <= 100) begin
      if (done === 1'b1) begin
        done_k = k;
      end else begin
        if (alu_start !== 1'b1) begin
          gaps++;
          n_tests++;
          if (!((k == 26 || k == 52) && busy === 1'b1 && cycle_num === 9'd0)) begin
            n_fail++; $display("FAIL multi_gap: got gap at k=%0d busy=%b cyc=%0d want k=26/52 busy=1 cyc=0", k, busy, cycle_num);
          end
        end
        if (k == 53) begin
          n_tests++;
          if ({alu_start, cycle_num, sram_raddr_w, sram_raddr_d} !== {1'b1, 9'd0, 10'h03E, 10'h09E}) begin
            n_fail++; $display("FAIL multi_t2_read: got %b %0d %h %h want 1 0 03e 09e", alu_start, cycle_num, sram_raddr_w, sram_raddr_d);
          end
        end
        if (k == 62) begin
          n_tests++;
          if ({sram_wen, matrix_index, sram_waddr} !== {1'b1, 6'd0, 10'h220}) begin
            n_fail++; $display("FAIL multi_t2_write: got %b %0d %h want 1 0 220", sram_wen, matrix_index, sram_waddr);
          end
        end
        if (k == 77) begin
          n_tests++;
          if ({cycle_num, matrix_index, sram_waddr} !== {9'd24, 6'd15, 10'h22F}) begin
            n_fail++; $display("FAIL multi_t2_last: got %0d %0d %h want 24 15 22f", cycle_num, matrix_index, sram_waddr);
          end
        end
        tick; k++;
      end
    end
    n_tests++;
    if (gaps != 2) begin
      n_fail++; $display("FAIL multi_gap_count: got %0d want 2", gaps);
    end
    n_tests++;
    if (done_k != 78) begin
      n_fail++; $display("FAIL multi_done_time: got %0d want 78", done_k);
    end
    tick;
  endtask

  task automatic test_zero_tiles;
    launch(6'd0, 10'h111, 10'h222, 10'h333);
    n_tests++;
    if ({done, busy, alu_start, sram_ren, sram_wen} !== 5'b11000) begin
      n_fail++; $display("FAIL zero_done: got %b want 11000", {done, busy, alu_start, sram_ren, sram_wen});
    end
    tick;
    n_tests++;
    if ({done, busy, alu_start, sram_ren, sram_wen} !== 5'b00000) begin
      n_fail++; $display("FAIL zero_after: got %b want 00000", {done, busy, alu_start, sram_ren, sram_wen});
    end
  endtask

  task automatic test_start_ignored;
    int k;
    launch(6'd1, 10'h000, 10'h100, 10'h300);
    repeat (4) tick;
    // Observing k=5; a start here must not restart or reconfigure the run.
    start = 1'b1; tile_num = 6'd5; w_base = 10'h155; d_base = 10'h0AA;
    tick;
    start = 1'b0;
    n_tests++;
    if ({cycle_num, sram_raddr_w, sram_raddr_d} !== {9'd5, 10'h005, 10'h105}) begin
      n_fail++; $display("FAIL ignore_run: got %0d %h %h want 5 005 105", cycle_num, sram_raddr_w, sram_raddr_d);
    end
    k = 6;
    while (done !== 1'b1 && k < 40) begin tick; k++; end
    n_tests++;
    if (k != 26) begin
      n_fail++; $display("FAIL ignore_done_time: got %0d want 26", k);
    end
    start = 1'b1; tile_num = 6'd0;
    tick;
    n_tests++;
    if ({busy, done} !== 2'b00) begin
      n_fail++; $display("FAIL ignore_done_cycle: got %b want 00", {busy, done});
    end
    tick;
    start = 1'b0;
    n_tests++;
    if ({busy, done} !== 2'b11) begin
      n_fail++; $display("FAIL accept_next_idle: got %b want 11", {busy, done});
    end
    tick;
  endtask

  task automatic test_reset_mid_run;
    int k, wen_cnt;
    bit stray;
    launch(6'd2, 10'h010, 10'h040, 10'h100);
    k = 1;
    while (k < 39) begin tick; k++; end
    n_tests++;
    if ({alu_start, cycle_num, sram_raddr_w, sram_raddr_d, sram_waddr} !== {1'b1, 9'd12, 10'h02B, 10'h05B, 10'h113}) begin
      n_fail++; $display("FAIL midrun_pre: got %b %0d %h %h %h want 1 12 02b 05b 113", alu_start, cycle_num, sram_raddr_w, sram_raddr_d, sram_waddr);
    end
    srst = 1'b1;
    tick;
    srst = 1'b0;
    n_tests++;
    if ({busy, done, alu_start, sram_ren, sram_wen, cycle_num, matrix_index, sram_raddr_w, sram_raddr_d, sram_waddr} !== 50'b0) begin
      n_fail++; $display("FAIL midrun_reset: got busy=%b alu=%b cyc=%0d ren=%b wen=%b want all 0", busy, alu_start, cycle_num, sram_ren, sram_wen);
    end
    stray = 1'b0;
    repeat (30) begin tick; if (done !== 1'b0 || busy !== 1'b0) stray = 1'b1; end
    n_tests++;
    if (stray) begin
      n_fail++; $display("FAIL midrun_stray: got done/busy activity after reset want none");
    end
    launch(6'd1, 10'h010, 10'h040, 10'h100);
    n_tests++;
    if ({cycle_num, sram_raddr_w, sram_raddr_d} !== {9'd0, 10'h010, 10'h040}) begin
      n_fail++; $display("FAIL restart_first: got %0d %h %h want 0 010 040", cycle_num, sram_raddr_w, sram_raddr_d);
    end
    k = 1; wen_cnt = 0;
    while (done !== 1'b1 && k < 40) begin
      if (sram_wen === 1'b1) wen_cnt++;
      tick; k++;
    end
    n_tests++;
    if (k != 26 || wen_cnt != 16) begin
      n_fail++; $display("FAIL restart_run: got done at %0d wen=%0d want 26 16", k, wen_cnt);
    end
    tick;
  endtask

  task automatic test_wrap;
    int k;
    launch(6'd1, 10'h3FA, 10'h000, 10'h000);
    k = 1;
    while (k < 6) begin tick; k++; end
    n_tests++;
    if (sram_raddr_w !== 10'h3FF) begin
      n_fail++; $display("FAIL wrap_pre: got %h want 3ff", sram_raddr_w);
    end
    tick; k++;
    n_tests++;
    if ({cycle_num, sram_raddr_w} !== {9'd6, 10'h000}) begin
      n_fail++; $display("FAIL wrap_at6: got %0d %h want 6 000", cycle_num, sram_raddr_w);
    end
    while (k < 15) begin tick; k++; end
    n_tests++;
    if (sram_raddr_w !== 10'h008) begin
      n_fail++; $display("FAIL wrap_at14: got %h want 008", sram_raddr_w);
    end
    while (done !== 1'b1 && k < 40) begin tick; k++; end
    tick;
  endtask

  initial begin
    test_reset;
    test_single_tile;
    test_multi_tile;
    test_zero_tiles;
    test_start_ignored;
    test_reset_mid_run;
    test_wrap;
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/systolic_ctrl.md
# systolic_ctrl

Sequencer for the 8x8 systolic multiply array. Accepts a start command with a tile count and SRAM base addresses, then for each tile issues weight/data SRAM reads, drives the array's `alu_start`/`cycle_num`, sweeps `matrix_index` over the result diagonals, and issues output-SRAM writes. Sits between the top-level command interface and the array/SRAM datapath.

## Interface
- `ARRAY_SIZE`, 8, array dimension. The fixed schedule below is specified for 8.
- `ADDR_WIDTH`, 10, SRAM address width.
- `TILE_W`, 6, width of the tile-count field.
- `clk`  in  1  sole clock.
- `srst`  in  1  reset. Synchronous, active-high (decided).
- `start`  in  1  one-cycle command strobe. Sampled only in IDLE.
- `tile_num`  in  TILE_W  number of tiles to run. Latched on accepted `start`.
- `w_base`, `d_base`, `o_base`  in  ADDR_WIDTH each  weight, data and output base addresses. Latched on accepted `start`.
- `busy`  out  1  high from the cycle after an accepted `start` until DONE is left.
- `done`  out  1  one-cycle pulse at the end of a command.
- `alu_start`  out  1  array enable.
- `cycle_num`  out  9  per-tile cycle counter to the array.
- `matrix_index`  out  6  diagonal select to the array.
- `sram_ren`  out  1  weight/data read enable, shared by w0/w1/d0/d1.
- `sram_raddr_w`, `sram_raddr_d`  out  ADDR_WIDTH each  read addresses.
- `sram_wen`  out  1  output write enable.
- `sram_waddr`  out  ADDR_WIDTH  output write address.

## Operation
- Constants: FIRST_OUT = ARRAY_SIZE+1 = 9; N_RD = 2*ARRAY_SIZE-1 = 15; N_WR = 2*ARRAY_SIZE = 16; LAST = FIRST_OUT+N_WR-1 = 24.
- FSM states: IDLE, RUN, GAP, DONE.
- **IDLE**
  - `start`=1 latches the configuration and clears the tile counter `t`.
  - If `tile_num`=0, go to DONE. Otherwise go to RUN with `cycle_num`=0.
- **RUN**
  - `alu_start`=1 and `cycle_num` increments by 1 each cycle, from 0 to LAST.
  - Reads: `sram_ren`=1 while `cycle_num` < N_RD. `sram_raddr_w` = `w_base` + `t`*N_RD + `cycle_num`; `sram_raddr_d` uses `d_base` with the same offset. When `sram_ren`=0, both addresses are 0.
  - Writes: `sram_wen`=1 while FIRST_OUT ≤ `cycle_num` ≤ LAST. In that window `matrix_index` = `cycle_num` − FIRST_OUT (0..15) and `sram_waddr` = `o_base` + `t`*N_WR + `matrix_index`. Outside the window, `matrix_index`=0 and `sram_waddr`=0.
  - At `cycle_num`=LAST: if `t`+1 = `tile_num`, go to DONE; otherwise go to GAP with `t` incremented.
- **GAP**
  - Lasts exactly one cycle with `alu_start`=0, which clears the array accumulators.
  - `cycle_num`=0, then go to RUN.
- **DONE**
  - `done`=1 for one cycle, then go to IDLE.
- Address arithmetic is modulo 2^ADDR_WIDTH and wraps silently.
- `start` is ignored outside IDLE. `start` in the DONE cycle is ignored; it is accepted in the following IDLE cycle.
- Configuration inputs may change freely after acceptance without effect.

## Timing
- Every output is registered.
- Reset values of all outputs are 0. State is IDLE and `t`=0.
- `start` accepted in cycle n:
  - `busy`=1 and `alu_start`=1 with `cycle_num`=0 in cycle n+1.
  - First `sram_wen` in cycle n+10.
- Per tile: 25 RUN cycles. Between tiles: 1 GAP cycle.
- Command length: from accepted `start` to the `done` pulse is 26·`tile_num` cycles. For `tile_num`=0, `done` is at n+1 and `alu_start` never rises.
- `busy` is high during RUN, GAP and DONE.
- SRAM read latency of one cycle is absorbed by the datapath. The controller makes no allowance for it.
- `srst` at any point, including mid-RUN: next cycle all outputs are 0 and the FSM is IDLE. No partial `done` is issued.

## Structure
- Shared package `systolic_pkg` holds:
  - ARRAY_SIZE, FIRST_OUT, N_RD, N_WR, LAST;
  - the FSM state enum;
  - the 9-bit `cycle_num` and 6-bit `matrix_index` widths, which are shared with the array.
- One sub-module, `systolic_addr_gen`: base + tile offset + counter adders for read and write addresses. Instantiated once, with the three bases passed in.
- FSM and counters live in `systolic_ctrl`.

## Test plan
- Reset, then `start` with `tile_num`=1, `w_base`=0x10, `d_base`=0x40, `o_base`=0x100:
  - `sram_raddr_w` runs 0x10..0x1E while `sram_ren`=1;
  - `sram_wen` on exactly 16 cycles, with `sram_waddr` 0x100..0x10F and `matrix_index` 0..15;
  - `done` 26 cycles after `start`.
- `tile_num`=3:
  - `alu_start` drops for exactly one cycle between tiles, twice in total;
  - tile 2 reads start at `w_base`+30 and writes at `o_base`+32;
  - `done` at 78 cycles.
- `tile_num`=0: `done` the cycle after `start`; `alu_start`, `sram_ren` and `sram_wen` stay 0.
- `start` pulsed during RUN and in the DONE cycle: ignored, with no change to counters or addresses. A `start` in the next IDLE cycle is accepted.
- `srst` asserted at `cycle_num`=12 of tile 1 of 2: all outputs are 0 the next cycle, no `done` is issued, and a fresh `start` runs a full, correct sequence.
- `w_base`=0x3FA with `ADDR_WIDTH`=10: read address wraps from 0x3FF to 0x000 at `cycle_num`=6.
